// File: rtl/entity_pkg.sv
// Shared op codes, orientations and field layout for the entity-descriptor slots.
package entity_pkg;

  localparam logic [1:0] OP_WRITE      = 2'b00;
  localparam logic [1:0] OP_CLEAR      = 2'b01;
  localparam logic [1:0] OP_MOVE       = 2'b10;
  localparam logic [1:0] OP_SET_ORIENT = 2'b11;

  localparam logic [1:0] ORIENT_UP    = 2'b00;
  localparam logic [1:0] ORIENT_RIGHT = 2'b01;
  localparam logic [1:0] ORIENT_DOWN  = 2'b10;
  localparam logic [1:0] ORIENT_LEFT  = 2'b11;

  localparam logic [3:0]  ID_BLANK     = 4'hF;
  localparam logic [13:0] ENTITY_BLANK = 14'h3C00;

  localparam int ID_LSB     = 10;
  localparam int ORIENT_LSB = 8;
  localparam int COL_LSB    = 4;
  localparam int ROW_LSB    = 0;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] orient;
    logic [3:0] col;
    logic [3:0] row;
  } entity_t;

endpackage

// File: rtl/entity_move_calc.sv
// Combinational one-step grid move: target cell plus a legality flag (no wrap at edges).
module entity_move_calc
  import entity_pkg::*;
#(
  parameter int GRID_COLS = 16,
  parameter int GRID_ROWS = 12
) (
  input  logic [3:0] col,
  input  logic [3:0] row,
  input  logic [1:0] dir,
  output logic [3:0] next_col,
  output logic [3:0] next_row,
  output logic       legal
);

  always_comb begin
    next_col = col;
    next_row = row;
    legal    = 1'b0;
    case (dir)
      ORIENT_UP: begin
        legal    = (row != 4'd0);
        next_row = row - 4'd1;
      end
      ORIENT_RIGHT: begin
        legal    = (int'(col) < GRID_COLS - 1);
        next_col = col + 4'd1;
      end
      ORIENT_DOWN: begin
        legal    = (int'(row) < GRID_ROWS - 1);
        next_row = row + 4'd1;
      end
      ORIENT_LEFT: begin
        legal    = (col != 4'd0);
        next_col = col - 4'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/entity_slot_writer.sv
// Double-buffered entity slot registers: ops land in shadow, copied to active at vblank start.
// Optional build macro ENTITY_WRITER_ERR_EN adds a sticky err output for rejected ops.
module entity_slot_writer
  import entity_pkg::*;
#(
  parameter int NUM_SLOTS = 5,
  parameter int V_VISIBLE = 480,
  parameter int GRID_COLS = 16,
  parameter int GRID_ROWS = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_slot,
  input  logic [1:0]              wr_op,
  input  logic [13:0]             wr_data,
  input  logic [9:0]              counter_H,
  input  logic [9:0]              counter_V,
  output logic [14*NUM_SLOTS-1:0] entities_out,
  output logic                    commit_pulse,
  output logic [7:0]              frame_cnt
`ifdef ENTITY_WRITER_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  entity_t    shadow [NUM_SLOTS];
  entity_t    active [NUM_SLOTS];
  logic [0:0] state;
  logic       dirty;
  logic       slot_ok, accept, trigger, apply;
  entity_t    cur, upd;
  logic [3:0] mv_col, mv_row;
  logic       mv_legal;

  assign slot_ok = (int'(wr_slot) < NUM_SLOTS);
  assign accept  = wr_valid & wr_ready;
  assign trigger = (counter_V == 10'(V_VISIBLE)) && (counter_H == '0);

  always_comb begin
    cur = ENTITY_BLANK;
    if (slot_ok) cur = shadow[IW'(wr_slot)];
  end

  entity_move_calc #(
    .GRID_COLS(GRID_COLS),
    .GRID_ROWS(GRID_ROWS)
  ) u_move (
    .col     (cur.col),
    .row     (cur.row),
    .dir     (wr_data[9:8]),
    .next_col(mv_col),
    .next_row(mv_row),
    .legal   (mv_legal)
  );

  // apply=0 marks a rejected op: bad slot, blank MOVE, or MOVE off the grid.
  always_comb begin
    upd   = cur;
    apply = 1'b0;
    if (slot_ok) begin
      case (wr_op)
        OP_WRITE: begin
          upd   = wr_data;
          apply = 1'b1;
        end
        OP_CLEAR: begin
          upd.id = ID_BLANK;
          apply  = 1'b1;
        end
        OP_SET_ORIENT: begin
          upd.orient = wr_data[9:8];
          apply      = 1'b1;
        end
        OP_MOVE: begin
          if (cur.id != ID_BLANK && mv_legal) begin
            upd.col    = mv_col;
            upd.row    = mv_row;
            upd.orient = wr_data[9:8];
            apply      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wr_ready  <= 1'b0;
      dirty     <= 1'b0;
      frame_cnt <= '0;
`ifdef ENTITY_WRITER_ERR_EN
      err       <= 1'b0;
`endif
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        shadow[IW'(i)] <= ENTITY_BLANK;
        active[IW'(i)] <= ENTITY_BLANK;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && apply) begin
            shadow[IW'(wr_slot)] <= upd;
            dirty                <= 1'b1;
          end
`ifdef ENTITY_WRITER_ERR_EN
          if (accept && !apply) err <= 1'b1;
`endif
          if (trigger) begin
            state     <= ST_COMMIT;
            frame_cnt <= frame_cnt + 8'd1;
            wr_ready  <= 1'b0;
          end else begin
            wr_ready  <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (dirty) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) active[IW'(i)] <= shadow[IW'(i)];
          end
          dirty    <= 1'b0;
`ifdef ENTITY_WRITER_ERR_EN
          err      <= 1'b0;
`endif
          state    <= ST_IDLE;
          wr_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign commit_pulse = (state == ST_COMMIT) && dirty;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_out
    assign entities_out[14*k +: 14] = active[k];
  end

endmodule

// File: tb/tb_entity_slot_writer.sv
// Randomized + directed bench for entity_slot_writer against an array-based frame model.
module tb_entity_slot_writer;

  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic [2:0]    wr_slot = '0;
  logic [1:0]    wr_op = '0;
  logic [13:0]   wr_data = '0;
  logic [9:0]    ch = '0;
  logic [9:0]    cv = '0;
  logic          wr_ready;
  logic [14*NS-1:0] ent;
  logic          commit_pulse;
  logic [7:0]    frame_cnt;
`ifdef ENTITY_WRITER_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  entity_slot_writer #(
    .NUM_SLOTS(NS),
    .V_VISIBLE(480),
    .GRID_COLS(16),
    .GRID_ROWS(12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_slot     (wr_slot),
    .wr_op       (wr_op),
    .wr_data     (wr_data),
    .counter_H   (ch),
    .counter_V   (cv),
    .entities_out(ent),
    .commit_pulse(commit_pulse),
    .frame_cnt   (frame_cnt)
`ifdef ENTITY_WRITER_ERR_EN
    ,
    .err         (err)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: one frame's worth of shadow/active descriptors as plain ints.
  int shadow_m [NS];
  int active_m [NS];
  bit dirty_m, err_m, commit_m, ready_m;
  int frame_m;

  function automatic void model_reset();
    for (int k = 0; k < NS; k++) begin
      shadow_m[k] = 'h3C00;
      active_m[k] = 'h3C00;
    end
    dirty_m = 0; err_m = 0; commit_m = 0; ready_m = 0; frame_m = 0;
  endfunction

  function automatic bit apply_op(input int slot, input int opc, input int d);
    int s, id, col, row, dir, nc, nr;
    int dc[4] = '{0, 1, 0, -1};
    int dr[4] = '{-1, 0, 1, 0};
    if (slot >= NS) return 0;
    s   = shadow_m[slot];
    id  = (s >> 10) & 15;
    col = (s >> 4) & 15;
    row = s & 15;
    dir = (d >> 8) & 3;
    case (opc)
      0: shadow_m[slot] = d;
      1: shadow_m[slot] = (s & 'h3FF) | 'h3C00;
      3: shadow_m[slot] = (s & 'h3CFF) | (d & 'h300);
      default: begin
        if (id == 15) return 0;
        nc = col + dc[dir];
        nr = row + dr[dir];
        if (nc < 0 || nc >= 16 || nr < 0 || nr >= 12) return 0;
        shadow_m[slot] = (id << 10) | (dir << 8) | (nc << 4) | nr;
      end
    endcase
    return 1;
  endfunction

  function automatic logic [79:0] exp_ent();
    logic [79:0] v = '0;
    for (int k = 0; k < NS; k++) v = v | (80'(active_m[k]) << (14 * k));
    return v;
  endfunction

  task automatic check_all();
    check("entities", 80'(ent), exp_ent());
    check("wr_ready", 80'(wr_ready), 80'(ready_m));
    check("commit_pulse", 80'(commit_pulse), 80'(commit_m && dirty_m));
    check("frame_cnt", 80'(frame_cnt), 80'(frame_m));
`ifdef ENTITY_WRITER_ERR_EN
    check("err", 80'(err), 80'(err_m));
`endif
  endtask

  task automatic tick();
    bit trig;
    @(posedge clk);
    trig = (cv == 10'd480) && (ch == 10'd0);
    if (commit_m) begin
      if (dirty_m) active_m = shadow_m;
      dirty_m = 0; err_m = 0; commit_m = 0;
    end else begin
      if (wr_valid && ready_m) begin
        if (apply_op(int'(wr_slot), int'(wr_op), int'(wr_data))) dirty_m = 1;
        else err_m = 1;
      end
      if (trig) begin
        frame_m  = (frame_m + 1) % 256;
        commit_m = 1;
      end
    end
    ready_m = !commit_m;
    #1;
    check_all();
  endtask

  task automatic send(input int slot, input int opc, input int d);
    wr_valid = 1'b1;
    wr_slot  = 3'(slot);
    wr_op    = 2'(opc);
    wr_data  = 14'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic trigger();
    cv = 10'd480;
    ch = 10'd0;
    tick();
    ch = 10'd1;
  endtask

  function automatic int rand_data(input int opc);
    if (opc == 0)
      return ($urandom_range(0, 15) << 10) | ($urandom_range(0, 3) << 8) |
             ($urandom_range(0, 15) << 4) | $urandom_range(0, 11);
    return $urandom_range(0, 16383);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", 80'(wr_ready), 80'(0));
    cv = '0;
    ch = '0;
    reset = 1'b1;
    #1;
    check("ready_after_release", 80'(wr_ready), 80'(0));
    tick();
    check("ready_second_cycle", 80'(wr_ready), 80'(1));
  endtask

  initial begin
    int f0, nops, opc;
    model_reset();
    do_reset();

    // Write is held in shadow until vblank start.
    cv = 10'd100; ch = 10'd5;
    send(2, 0, 'h0A53);
    repeat (3) tick();
    check("t2_hold", 80'(ent[41:28]), 80'(14'h3C00));
    trigger();
    check("t2_pulse", 80'(commit_pulse), 80'(1));
    tick();
    check("t2_slot2", 80'(ent[41:28]), 80'(14'h0A53));

    // Edge-rejected move, then a legal move down.
    cv = 10'd100;
    send(1, 0, 'h04F3);
    send(1, 2, 'h0100);
`ifdef ENTITY_WRITER_ERR_EN
    check("t3_err", 80'(err), 80'(1));
`endif
    send(1, 2, 'h0200);
    trigger();
    tick();
    check("t3_move_down", 80'(ent[27:14]), 80'(14'h06F4));

    // Op on the trigger cycle joins this commit; op held through COMMIT lands next frame.
    cv = 10'd480; ch = 10'd0;
    wr_valid = 1'b1; wr_slot = 3'd3; wr_op = 2'd0; wr_data = 14'h1234;
    tick();
    check("t4_ready_low", 80'(wr_ready), 80'(0));
    ch = 10'd1; wr_data = 14'h0511;
    tick();
    check("t4_in_commit", 80'(ent[55:42]), 80'(14'h1234));
    tick();
    wr_valid = 1'b0;
    cv = 10'd100;
    tick();
    check("t4_not_yet", 80'(ent[55:42]), 80'(14'h1234));
    trigger();
    tick();
    check("t4_next_frame", 80'(ent[55:42]), 80'(14'h0511));

    // Empty frame still counts; frame counter wraps after 256 frames.
    cv = 10'd100;
    repeat (3) tick();
    trigger();
    check("t5_no_pulse", 80'(commit_pulse), 80'(0));
    tick();
    f0 = frame_m;
    repeat (256) begin
      trigger();
      tick();
    end
    check("t5_wrap", 80'(frame_cnt), 80'(f0 % 256));

    // Out-of-range slot is swallowed.
    cv = 10'd100;
    send(7, 0, 'h0123);
`ifdef ENTITY_WRITER_ERR_EN
    check("t6_err", 80'(err), 80'(1));
`endif
    trigger();
    check("t6_no_pulse", 80'(commit_pulse), 80'(0));
    tick();

    // Random frames.
    repeat (60) begin
      cv = 10'd100;
      nops = $urandom_range(0, 6);
      repeat (nops) begin
        ch  = 10'($urandom_range(1, 799));
        opc = $urandom_range(0, 3);
        if ($urandom_range(0, 3) != 0) send($urandom_range(0, 7), opc, rand_data(opc));
        else tick();
      end
      cv = 10'd480; ch = 10'd0;
      opc = $urandom_range(0, 3);
      wr_valid = 1'($urandom_range(0, 1));
      wr_slot  = 3'($urandom_range(0, 7));
      wr_op    = 2'(opc);
      wr_data  = 14'(rand_data(opc));
      tick();
      wr_valid = 1'b0;
      ch = 10'd1;
      tick();
    end

    // Reset asserted mid-frame blanks everything at once.
    cv = 10'd200;
    send(0, 0, 'h0123);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
